// File: rtl/block_serializer_pkg.sv
// Shared widths, state encoding and per-block byte count for block_serializer.
// Honours BLKSER_CKSUM_EN: when defined, each block gains a trailing XOR checksum byte.
package block_serializer_pkg;

  localparam int BLOCK_W = 128;
  localparam int BYTE_W  = 8;
  localparam int NBYTES  = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

`ifdef BLKSER_CKSUM_EN
  localparam logic [4:0] LAST_CNT = 5'd16;
`else
  localparam logic [4:0] LAST_CNT = 5'd15;
`endif

endpackage

// File: rtl/block_serializer.sv
// Holds one 128-bit block and streams it out a byte per valid/ready handshake.
// Optional BLKSER_CKSUM_EN appends a 17th byte holding the XOR of the 16 data bytes.
module block_serializer
  import block_serializer_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BLOCK_W-1:0] in_block,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [BYTE_W-1:0]  out_byte,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               busy
);

  state_e             state_q, state_d;
  logic [4:0]         count_q, count_d;
  logic [BLOCK_W-1:0] block_q, block_d;
  logic [BYTE_W-1:0]  data_byte;
  logic               take;
`ifdef BLKSER_CKSUM_EN
  logic [BYTE_W-1:0]  cksum_q, cksum_d;
`endif

  function automatic logic [BYTE_W-1:0] sel_byte(input logic [BLOCK_W-1:0] blk,
                                                 input logic [4:0]         cnt);
    logic [3:0] idx;
    idx = MSB_FIRST ? 4'(5'd15 - cnt) : cnt[3:0];
    return blk[BYTE_W*idx +: BYTE_W];
  endfunction

  always_comb begin
    data_byte = sel_byte(block_q, count_q);
    out_valid = (state_q == ST_SEND);
    busy      = out_valid;
    out_last  = out_valid && (count_q == LAST_CNT);
    out_byte  = '0;
    if (out_valid) begin
`ifdef BLKSER_CKSUM_EN
      out_byte = out_last ? cksum_q : data_byte;
`else
      out_byte = data_byte;
`endif
    end
    take     = out_valid && out_ready;
    in_ready = (state_q == ST_IDLE) || (take && out_last);

    state_d = state_q;
    count_d = count_q;
    block_d = block_q;
`ifdef BLKSER_CKSUM_EN
    cksum_d = cksum_q;
`endif
    if (take) begin
      if (out_last) begin
        state_d = ST_IDLE;
        count_d = '0;
      end else begin
        count_d = count_q + 5'd1;
`ifdef BLKSER_CKSUM_EN
        cksum_d = cksum_q ^ data_byte;
`endif
      end
    end
    // A new block can land on the same edge the previous block's last byte leaves.
    if (in_valid && in_ready) begin
      state_d = ST_SEND;
      count_d = '0;
      block_d = in_block;
`ifdef BLKSER_CKSUM_EN
      cksum_d = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      block_q <= '0;
`ifdef BLKSER_CKSUM_EN
      cksum_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      block_q <= block_d;
`ifdef BLKSER_CKSUM_EN
      cksum_q <= cksum_d;
`endif
    end
  end

endmodule

// File: tb/tb_block_serializer.sv
// Bench for block_serializer: queue-based byte-stream model, directed cases and random traffic.
module tb_block_serializer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] in_block;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   out_byte;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         busy;

  localparam logic [127:0] BLK_A = 128'h12_34_56_78_9a_7a_bc_de_f0_11_22_33_44_55_66_58;
  localparam logic [127:0] BLK_B = {16{8'hA5}};

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  logic [7:0] seen[$];
  bit         primed = 1'b0;

  always #5 clk = ~clk;

  block_serializer #(.MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_block(in_block), .in_valid(in_valid),
    .in_ready(in_ready), .out_byte(out_byte), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected stream of one block: byte 15 first down to byte 0, then optional XOR byte.
  function automatic void push_block(input logic [127:0] b);
    logic [7:0] x;
    x = 8'h00;
    for (int k = 15; k >= 0; k--) begin
      q.push_back(b[8*k +: 8]);
      x ^= b[8*k +: 8];
    end
`ifdef BLKSER_CKSUM_EN
    q.push_back(x);
`endif
  endfunction

  // Check on the falling edge, then advance the model to what the next rising edge does.
  always @(negedge clk) begin
    bit take, rdy, nonempty;
    nonempty = (q.size() != 0);
    if (primed) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, nonempty});
      chk("busy", {31'd0, busy}, {31'd0, nonempty});
      chk("in_ready", {31'd0, in_ready},
          {31'd0, (!nonempty) || (out_ready && q.size() == 1)});
      chk("out_byte", {24'd0, out_byte}, {24'd0, nonempty ? q[0] : 8'h00});
      chk("out_last", {31'd0, out_last}, {31'd0, q.size() == 1});
      if (out_valid && out_ready) seen.push_back(out_byte);
    end
    if (!rst_n) begin
      q.delete();
      primed = 1'b1;
    end else if (primed) begin
      take = nonempty && out_ready;
      rdy  = !nonempty || (take && q.size() == 1);
      if (take) void'(q.pop_front());
      if (in_valid && rdy) push_block(in_block);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [127:0] b);
    in_block = b;
    in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; in_block = BLK_A; out_ready = 1'b1;
    // Reset held two cycles while in_valid is high
    tick(2);
    rst_n = 1'b1; in_valid = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_byte", {24'd0, out_byte}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Single block, out_ready high
    seen.delete();
    send_one(BLK_A);
    chk("lat_first_valid", {31'd0, out_valid}, 32'd1);
    tick(17);
    chk("single_len", seen.size(), 32'd16);
    if (seen.size() == 16) begin
      chk("single_b0", {24'd0, seen[0]}, 32'h12);
      chk("single_b5", {24'd0, seen[5]}, 32'h7a);
      chk("single_b15", {24'd0, seen[15]}, 32'h58);
    end

    // Same block with out_ready toggling
    seen.delete();
    out_ready = 1'b0;
    send_one(BLK_A);
    for (int i = 0; i < 34; i++) begin
      out_ready = ~out_ready;
      tick(1);
    end
    out_ready = 1'b1;
    tick(4);
    chk("toggle_len", seen.size(), 32'd16);
    if (seen.size() == 16) begin
      chk("toggle_b0", {24'd0, seen[0]}, 32'h12);
      chk("toggle_b15", {24'd0, seen[15]}, 32'h58);
    end

    // Back-to-back: B waits on in_valid and is taken with A's last byte
    seen.delete();
    in_block = BLK_A; in_valid = 1'b1;
    tick(1);
    in_block = BLK_B;
    tick(15);
    chk("b2b_accept_rdy", {31'd0, in_ready}, 32'd1);
    tick(1);
    in_valid = 1'b0;
    chk("b2b_no_gap", {31'd0, out_valid}, 32'd1);
    chk("b2b_first_b", {24'd0, out_byte}, 32'hA5);
    tick(18);
    chk("b2b_len", seen.size(), 32'd32);
    if (seen.size() == 32) begin
      chk("b2b_a_last", {24'd0, seen[15]}, 32'h58);
      chk("b2b_b_first", {24'd0, seen[16]}, 32'hA5);
    end

    // Reset after eight bytes have left
    seen.delete();
    send_one(BLK_A);
    tick(8);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_byte", {24'd0, out_byte}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    seen.delete();
    send_one(BLK_A);
    tick(17);
    chk("midrst_restart", seen.size() > 0 ? {24'd0, seen[0]} : 32'hFFFF, 32'h12);

`ifdef BLKSER_CKSUM_EN
    seen.delete();
    send_one(128'h0F0E0D0C_0B0A0908_07060504_03020100);
    tick(18);
    chk("ck_len", seen.size(), 32'd17);
    if (seen.size() == 17) chk("ck_seq", {24'd0, seen[16]}, 32'h00);
    seen.delete();
    send_one({8'h01, 120'd0});
    tick(18);
    if (seen.size() == 17) chk("ck_one", {24'd0, seen[16]}, 32'h01);
    else chk("ck_one_len", seen.size(), 32'd17);
`endif

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      in_block  = {$urandom, $urandom, $urandom, $urandom};
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 9) < 7);
      rst_n     = ($urandom_range(0, 199) != 0);
      tick(1);
    end
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick(20);
    chk("drain_idle", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
